// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: one-hot control bit
// positions and the transaction FSM state type.
package mem_pkg;

  // EX_MEM_loadcntrl is one-hot {LHU,LBU,LW,LH,LB}
  localparam int LD_LB  = 0;
  localparam int LD_LH  = 1;
  localparam int LD_LW  = 2;
  localparam int LD_LBU = 3;
  localparam int LD_LHU = 4;

  // EX_MEM_storecntrl is one-hot {SW,SH,SB}
  localparam int ST_SB = 0;
  localparam int ST_SH = 1;
  localparam int ST_SW = 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

endpackage

// File: rtl/ls_align.sv
// Byte-lane steering for stores (replicated data + byte enables) and lane
// selection with sign/zero extension for loads.
module ls_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [4:0]  loadcntrl,
  input  logic [2:0]  storecntrl,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_val
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wdata = rs2;
    be    = 4'b1111;
    if (storecntrl[ST_SB]) begin
      wdata = {4{rs2[7:0]}};
      be    = 4'b0001 << addr_lo;
    end else if (storecntrl[ST_SH]) begin
      wdata = {2{rs2[15:0]}};
      be    = 4'b0011 << addr_lo;
    end else if (storecntrl[ST_SW]) begin
      wdata = rs2;
      be    = 4'b1111;
    end

    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    load_val = rdata;
    if (loadcntrl[LD_LB])       load_val = {{24{byte_sel[7]}}, byte_sel};
    else if (loadcntrl[LD_LH])  load_val = {{16{half_sel[15]}}, half_sel};
    else if (loadcntrl[LD_LBU]) load_val = {24'b0, byte_sel};
    else if (loadcntrl[LD_LHU]) load_val = {16'b0, half_sel};
    else if (loadcntrl[LD_LW])  load_val = rdata;
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a req/ack data-memory port, stalls upstream while
// a transaction is outstanding and registers the MEM_WB writeback result.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        dbg,
  input  logic        EX_MEM_memread,
  input  logic        EX_MEM_memwrite,
  input  logic        EX_MEM_regwrite,
  input  logic [4:0]  EX_MEM_rd,
  input  logic [31:0] EX_MEM_alures,
  input  logic [31:0] EX_MEM_dout_rs2,
  input  logic [4:0]  EX_MEM_loadcntrl,
  input  logic [2:0]  EX_MEM_storecntrl,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_hold,
  output logic        MEM_WB_regwrite,
  output logic [4:0]  MEM_WB_rd,
  output logic [31:0] WB_res,
  output logic        misalign_exc,
  output logic        bus_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic        access, is_load, misaligned, launch, update, in_done;
  logic [1:0]  addr_lo;
  logic [31:0] load_val;

  assign addr_lo = EX_MEM_alures[1:0];
  assign access  = EX_MEM_memread | EX_MEM_memwrite;
  assign is_load = EX_MEM_memread & ~EX_MEM_memwrite;
  assign in_done = (state == DONE);

  always_comb begin
    misaligned = 1'b0;
    if (EX_MEM_memwrite)
      misaligned = (EX_MEM_storecntrl[ST_SH] & addr_lo[0]) |
                   (EX_MEM_storecntrl[ST_SW] & (addr_lo != 2'b00));
    else if (EX_MEM_memread)
      misaligned = ((EX_MEM_loadcntrl[LD_LH] | EX_MEM_loadcntrl[LD_LHU]) & addr_lo[0]) |
                   (EX_MEM_loadcntrl[LD_LW] & (addr_lo != 2'b00));
  end

  // Request is raised combinationally in IDLE so the access costs only 3 cycles
  assign launch    = (state == IDLE) & access & ~misaligned & ~dbg & ~Rst;
  assign dmem_req  = launch | (state == BUSY);
  assign mem_hold  = dmem_req;
  assign dmem_we   = dmem_req & EX_MEM_memwrite;
  assign dmem_addr = {EX_MEM_alures[31:2], 2'b00};
  assign update    = ~dbg & ~mem_hold;

  ls_align u_align (
    .addr_lo    (addr_lo),
    .loadcntrl  (EX_MEM_loadcntrl),
    .storecntrl (EX_MEM_storecntrl),
    .rs2        (EX_MEM_dout_rs2),
    .rdata      (rdata_q),
    .wdata      (dmem_wdata),
    .be         (dmem_be),
    .load_val   (load_val)
  );

  // Transaction FSM; the launch cycle counts as cycle 0 of the timeout window
  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (launch) begin
          state <= BUSY;
          cnt   <= CNT_W'(1);
          err_q <= 1'b0;
        end
        BUSY: if (dmem_ack) begin
          state <= DONE;
        end else if (cnt == CNT_LAST) begin
          state <= DONE;
          err_q <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: if (!dbg) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == BUSY && dmem_ack) rdata_q <= dmem_rdata;
  end

  // MEM_WB boundary
  always_ff @(posedge clk) begin
    if (Rst) begin
      MEM_WB_regwrite <= 1'b0;
      MEM_WB_rd       <= '0;
      WB_res          <= '0;
      misalign_exc    <= 1'b0;
      bus_err         <= 1'b0;
    end else begin
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      if (update) begin
        MEM_WB_rd       <= EX_MEM_rd;
        WB_res          <= (is_load & in_done) ? load_val : EX_MEM_alures;
        MEM_WB_regwrite <= EX_MEM_regwrite & ~misaligned & ~(in_done & err_q);
        misalign_exc    <= access & misaligned & ~in_done;
        bus_err         <= in_done & err_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: a transaction-level model sets the
// expected outputs per cycle and a single negedge process compares them.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;
  localparam int T_NONE = 0, T_LB = 1, T_SH = 2, T_MIS = 3, T_TO = 4,
                 T_ADD = 5, T_RST = 6, T_LBU = 7;

  logic        clk = 1'b0;
  logic        Rst, dbg;
  logic        memread, memwrite, regwrite;
  logic [4:0]  rd_in;
  logic [31:0] alures, rs2;
  logic [4:0]  loadcntrl;
  logic [2:0]  storecntrl;
  logic        dmem_req, dmem_we, dmem_ack, mem_hold;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        MEM_WB_regwrite, misalign_exc, bus_err;
  logic [4:0]  MEM_WB_rd;
  logic [31:0] WB_res;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .Rst(Rst), .dbg(dbg),
    .EX_MEM_memread(memread), .EX_MEM_memwrite(memwrite),
    .EX_MEM_regwrite(regwrite), .EX_MEM_rd(rd_in),
    .EX_MEM_alures(alures), .EX_MEM_dout_rs2(rs2),
    .EX_MEM_loadcntrl(loadcntrl), .EX_MEM_storecntrl(storecntrl),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .mem_hold(mem_hold),
    .MEM_WB_regwrite(MEM_WB_regwrite), .MEM_WB_rd(MEM_WB_rd),
    .WB_res(WB_res), .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  // Expected state, written only by the stimulus process
  logic        e_req, e_hold, e_we, e_rw, e_mis, e_err, e_wb_chk;
  logic [31:0] e_addr, e_wdata, e_wb;
  logic [3:0]  e_be;
  logic [4:0]  e_rd;
  int          tag;

  // Written only by the compare process
  int          vectors = 0, miscompares = 0, hold_run = 0;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  function automatic logic m_mis(input logic r, input logic w, input logic [4:0] lc,
                                 input logic [2:0] sc, input logic [1:0] a);
    if (w) return (sc[1] && a[0]) || (sc[2] && a != 2'd0);
    if (r) return ((lc[1] || lc[4]) && a[0]) || (lc[2] && a != 2'd0);
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [4:0] lc, input logic [1:0] a,
                                         input logic [31:0] word);
    logic [31:0] s;
    s = word >> (8 * a);
    if (lc[0]) return 32'($signed(s[7:0]));
    if (lc[1]) return 32'($signed(s[15:0]));
    if (lc[3]) return {24'b0, s[7:0]};
    if (lc[4]) return {16'b0, s[15:0]};
    return word;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] sc, input logic [1:0] a);
    if (sc[0]) return 4'(1 << a);
    if (sc[1]) return 4'(3 << a);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] sc, input logic [31:0] d);
    if (sc[0]) return {4{d[7:0]}};
    if (sc[1]) return {2{d[15:0]}};
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    case (tag)
      T_LB: begin
        chk("lb_wb_res", WB_res, 32'hFFFF_FF80);
        chk("lb_regwrite", 32'(MEM_WB_regwrite), 32'd1);
        chk("lb_hold_cycles", 32'(hold_run), 32'd2);
      end
      T_SH: begin
        chk("sh_addr", cap_addr, 32'h0000_0200);
        chk("sh_be", 32'(cap_be), 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(cap_we), 32'd1);
        chk("sh_regwrite", 32'(MEM_WB_regwrite), 32'd0);
      end
      T_MIS: begin
        chk("mis_exc", 32'(misalign_exc), 32'd1);
        chk("mis_regwrite", 32'(MEM_WB_regwrite), 32'd0);
        chk("mis_hold_cycles", 32'(hold_run), 32'd0);
      end
      T_TO: begin
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_regwrite", 32'(MEM_WB_regwrite), 32'd0);
        chk("to_hold_cycles", 32'(hold_run), 32'(TIMEOUT));
      end
      T_ADD: begin
        chk("add_wb_res", WB_res, 32'hDEAD_BEEF);
        chk("add_hold_cycles", 32'(hold_run), 32'd0);
      end
      T_RST: begin
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_hold", 32'(mem_hold), 32'd0);
        chk("rst_wb_res", WB_res, 32'd0);
        chk("rst_rd", 32'(MEM_WB_rd), 32'd0);
      end
      T_LBU: begin
        chk("lbu_wb_res", WB_res, 32'h0000_00FF);
        chk("lbu_regwrite", 32'(MEM_WB_regwrite), 32'd1);
      end
      default: ;
    endcase
    if (tag != T_NONE) hold_run = 0;
    if (mem_hold) hold_run++;
    if (dmem_req) begin
      cap_we = dmem_we; cap_addr = dmem_addr; cap_be = dmem_be; cap_wdata = dmem_wdata;
    end

    chk("dmem_req", 32'(dmem_req), 32'(e_req));
    chk("mem_hold", 32'(mem_hold), 32'(e_hold));
    if (e_req) begin
      chk("dmem_we", 32'(dmem_we), 32'(e_we));
      chk("dmem_addr", dmem_addr, e_addr);
      if (e_we) begin
        chk("dmem_be", 32'(dmem_be), 32'(e_be));
        chk("dmem_wdata", dmem_wdata, e_wdata);
      end
    end
    chk("MEM_WB_regwrite", 32'(MEM_WB_regwrite), 32'(e_rw));
    chk("MEM_WB_rd", 32'(MEM_WB_rd), 32'(e_rd));
    chk("misalign_exc", 32'(misalign_exc), 32'(e_mis));
    chk("bus_err", 32'(bus_err), 32'(e_err));
    if (e_wb_chk) chk("WB_res", WB_res, e_wb);
  end

  task automatic step();
    @(posedge clk);
    #1;
    tag = T_NONE;
    e_mis = 1'b0;
    e_err = 1'b0;
  endtask

  task automatic set_wb(input logic rw, input logic [4:0] rd, input logic [31:0] wb,
                        input logic wb_chk, input logic mis, input logic err);
    e_rw = rw; e_rd = rd; e_wb = wb; e_wb_chk = wb_chk; e_mis = mis; e_err = err;
  endtask

  // One instruction from presentation in EX_MEM until its MEM_WB update edge.
  // delay = BUSY cycle index carrying ack; >= TIMEOUT-1 means ack withheld.
  task automatic issue(input logic r, input logic w, input logic rw, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] d, input logic [31:0] rdata,
                       input logic [4:0] lc, input logic [2:0] sc, input int delay,
                       input int dbgc);
    logic acc, mis, ld, to;
    memread = r; memwrite = w; regwrite = rw; rd_in = rd; alures = addr; rs2 = d;
    loadcntrl = lc; storecntrl = sc; dbg = 1'b0;
    acc = r | w;
    ld  = r & ~w;
    mis = m_mis(r, w, lc, sc, addr[1:0]);
    if (acc && !mis) begin
      e_req = 1'b1; e_hold = 1'b1; e_we = w;
      e_addr = {addr[31:2], 2'b00}; e_be = m_be(sc, addr[1:0]); e_wdata = m_wdata(sc, d);
      step();
      if (dbgc > 0) dbg = 1'b1;
      for (int k = 0; k < TIMEOUT - 1; k++) begin
        dmem_ack = (k == delay);
        dmem_rdata = (k == delay) ? rdata : $urandom;
        step();
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        if (k == delay) break;
      end
      e_req = 1'b0; e_hold = 1'b0;
      repeat (dbgc) step();
      dbg = 1'b0;
      step();
      to = (delay >= TIMEOUT - 1);
      set_wb(rw & ~to, rd, ld ? m_load(lc, addr[1:0], rdata) : addr, ~(ld & to), 1'b0, to);
    end else begin
      e_req = 1'b0; e_hold = 1'b0;
      step();
      set_wb(rw & ~mis, rd, addr, ~mis, mis, 1'b0);
    end
  endtask

  initial begin
    logic r, w;
    int kind, p, dly, dbgc;
    Rst = 1'b1; dbg = 1'b0; memread = 1'b0; memwrite = 1'b0; regwrite = 1'b0;
    rd_in = '0; alures = '0; rs2 = '0; loadcntrl = '0; storecntrl = '0;
    dmem_ack = 1'b0; dmem_rdata = '0; tag = T_NONE;
    e_req = 1'b0; e_hold = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
    set_wb(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    Rst = 1'b0;

    issue(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0103, $urandom, 32'h80FF_FF12, 5'b00001, 3'b001, 0, 0);
    tag = T_LB;
    issue(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0202, 32'h1234_ABCD, $urandom, 5'b00100, 3'b010, 0, 0);
    tag = T_SH;
    issue(1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0301, $urandom, $urandom, 5'b00100, 3'b100, 0, 0);
    tag = T_MIS;
    issue(1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0400, $urandom, $urandom, 5'b00100, 3'b100, 20, 0);
    tag = T_TO;
    issue(1'b0, 1'b0, 1'b1, 5'd6, 32'hDEAD_BEEF, $urandom, $urandom, 5'b00001, 3'b001, 0, 0);
    tag = T_ADD;

    // dbg in IDLE holds off an aligned load and the MEM_WB update
    memread = 1'b1; memwrite = 1'b0; regwrite = 1'b1; rd_in = 5'd8; alures = 32'h500;
    loadcntrl = 5'b00100; storecntrl = 3'b100; dbg = 1'b1;
    e_req = 1'b0; e_hold = 1'b0;
    step();
    issue(1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0500, $urandom, 32'h0BAD_F00D, 5'b00100, 3'b100, 1, 2);

    for (int n = 0; n < 160; n++) begin
      kind = $urandom_range(0, 9);
      r = (kind <= 3) || (kind == 7);
      w = (kind >= 4) && (kind <= 7);
      p = $urandom_range(0, 19);
      dly = (p < 12) ? $urandom_range(0, 3) : (p < 18) ? $urandom_range(4, TIMEOUT - 2) : 20;
      dbgc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      issue(r, w, 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
            5'(1 << $urandom_range(0, 4)), 3'(1 << $urandom_range(0, 2)), dly, dbgc);
    end

    // Reset in the middle of a BUSY load
    memread = 1'b1; memwrite = 1'b0; regwrite = 1'b1; rd_in = 5'd9; alures = 32'h600;
    loadcntrl = 5'b00100; storecntrl = 3'b100; dbg = 1'b0;
    e_req = 1'b1; e_hold = 1'b1; e_we = 1'b0; e_addr = 32'h600;
    step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    memread = 1'b0; regwrite = 1'b0; rd_in = 5'd0; alures = 32'd0;
    e_req = 1'b0; e_hold = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    tag = T_RST;
    step();
    set_wb(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0000, $urandom, 32'h0000_00FF, 5'b01000, 3'b001, 0, 0);
    tag = T_LBU;
    memread = 1'b0; memwrite = 1'b0;
    e_req = 1'b0; e_hold = 1'b0;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
